apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//  Shares one downstream APB master port (peripheral bus) between NUM_MASTERS upstream
//  APB requesters, e.g. the AXI-to-APB bridge and a debug/DMA APB master.
//  Round-robin arbitration; re-issues the granted transfer downstream with correct
//  SETUP/ACCESS phasing and routes the completion back to the winner only.
// PARAMETERS
//  NUM_MASTERS     2    number of upstream APB requesters (2..8)
//  APB_ADDR_WIDTH  32   paddr width
//  APB_DATA_WIDTH  32   pwdata/prdata width
//  TIMEOUT_CYCLES  256  ACCESS-phase watchdog limit (used only with APB_ARB_TIMEOUT_EN)
// PORTS
//  clk_i        in   1        clock
//  rst_ni       in   1        reset, synchronous, active-low
//  m_psel_i     in   N        upstream psel, one bit per master
//  m_penable_i  in   N        upstream penable (ignored for arbitration, protocol only)
//  m_pwrite_i   in   N        upstream pwrite
//  m_paddr_i    in   N*AW     upstream paddr, master k at [k*AW +: AW]
//  m_pwdata_i   in   N*DW     upstream pwdata, master k at [k*DW +: DW]
//  m_prdata_o   out  DW       read data, broadcast; valid only with that master's pready
//  m_pready_o   out  N        upstream pready, at most one bit set
//  m_pslverr_o  out  N        upstream pslverr, qualified by m_pready_o
//  psel_o       out  1        downstream psel
//  penable_o    out  1        downstream penable
//  pwrite_o     out  1        downstream pwrite (registered at grant)
//  paddr_o      out  AW       downstream paddr (registered at grant)
//  pwdata_o     out  DW       downstream pwdata (registered at grant)
//  prdata_i     in   DW       downstream read data
//  pready_i     in   1        downstream pready
//  pslverr_i    in   1        downstream pslverr
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): state IDLE, psel_o/penable_o/pwrite_o=0, paddr_o/pwdata_o=0,
//    grant index=0, RR pointer=0 (master 0 highest priority). m_pready_o/m_pslverr_o=0.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE.
//    IDLE: if any m_psel_i set, choose winner = first requester at/after RR pointer
//      (wrap modulo N); register pwrite/paddr/pwdata of winner, go SETUP.
//    SETUP: psel_o=1, penable_o=0; always -> ACCESS next cycle.
//    ACCESS: psel_o=1, penable_o=1; stay until pready_i=1; then -> IDLE,
//      RR pointer = winner+1 (wrap).
//  - Completion: m_pready_o[winner]=pready_i & (state==ACCESS), combinational;
//    m_pslverr_o[winner]=pslverr_i likewise; m_prdata_o=prdata_i passthrough.
//    Non-granted bits of m_pready_o/m_pslverr_o are always 0.
//  - Latency: request seen in IDLE -> downstream SETUP next cycle; min 3 cycles from
//    psel_i to pready_o (zero-wait slave). One IDLE cycle between transfers always.
//  - Requests arriving during SETUP/ACCESS are held by the requester (APB waits on
//    pready); arbiter never drops or reorders a held request.
//  - Upstream signals changing mid-transfer do not affect downstream (registered copy).
//  - Winner deasserting psel_i mid-transfer (protocol violation): transfer still completes
//    downstream; pready is returned regardless.
//  - Reset mid-transfer: immediate return to reset state; downstream transfer abandoned.
// CONFIGURATION
//  APB_ARB_TIMEOUT_EN defined: cycle counter runs in ACCESS; when it reaches
//    TIMEOUT_CYCLES-1 with pready_i=0, next cycle m_pready_o[winner]=1,
//    m_pslverr_o[winner]=1, psel_o/penable_o=0, state -> IDLE, RR pointer advances.
//    Counter clears on entry to SETUP. pready_i on the limit cycle wins (normal completion).
//  Not defined: no counter; ACCESS waits indefinitely for pready_i.
// STRUCTURE
//  apb_arb_pkg: state enum typedef (IDLE/SETUP/ACCESS), grant index width
//    localparam/function (clog2 of NUM_MASTERS, min 1), timeout counter width.
//  Sub-module apb_rr_picker: combinational round-robin pick from request vector and
//    pointer -> one-hot grant + index + valid. Top holds FSM, registers, routing.
// TESTING
//  1 Single write: m0 psel, addr 0x1A10_0004, data 0xDEAD_BEEF, slave 0-wait -> downstream
//    SETUP@+1, ACCESS@+2, m_pready_o=01@+2, pwdata_o=0xDEAD_BEEF.
//  2 Simultaneous m0+m1 reads held 4 transfers -> grants alternate 0,1,0,1; each
//    m_prdata_o matches slave data.
//  3 Wait-state slave (pready low 5 cycles) -> penable_o held 5 cycles, m1 request
//    waits, no upstream pready until slave ready.
//  4 pslverr_i=1 on m1 read completion -> m_pslverr_o=10, m_pready_o=10, m0 bits 0.
//  5 Reset asserted during ACCESS -> next cycle psel_o=0, penable_o=0, pointer=0;
//    m0 wins first post-reset request when both request.
//  6 (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) slave never ready -> after 16 ACCESS cycles
//    m_pready_o[winner]=1 with pslverr=1, psel_o drops, next requester granted.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and sizing helpers for the APB master arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apb_arb_pkg;

  // Arbiter FSM state encoding. Kept as plain constants so that older tools can consume it.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_SETUP  = 2'd1;
  localparam arb_state_t ST_ACCESS = 2'd2;

  // Width of a grant index. This is never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the ACCESS-phase watchdog counter. It must be able to hold t-1.
  function automatic int cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Round-robin picker: takes the first set request at or after ptr, wrapping modulo NUM_MASTERS.
// Latency: purely combinational.
// Backpressure: none. The caller decides when to act on the result.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] gnt_oh,
  output logic [IW-1:0]          gnt_idx,
  output logic                   gnt_vld
);

  logic [IW:0] k;

  // The scan runs from the farthest offset to the nearest one, so the candidate closest to ptr is written last and wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      k = {1'b0, ptr} + (IW+1)'(i);
      if (k >= (IW+1)'(NUM_MASTERS)) begin
        k = k - (IW+1)'(NUM_MASTERS);
      end
      if (req[k[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = k[IW-1:0];
      end
    end
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one downstream APB port between NUM_MASTERS upstream requesters (round-robin).
// Latency: grant in IDLE -> SETUP next cycle; at least 3 cycles from psel to pready; one IDLE cycle between transfers.
// Backpressure: losers hold psel until their pready; ACCESS waits on pready_i (watchdog optional via APB_ARB_TIMEOUT_EN).
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_MASTERS-1:0]                m_psel_i,
  input  logic [NUM_MASTERS-1:0]                m_penable_i,
  input  logic [NUM_MASTERS-1:0]                m_pwrite_i,
  input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0] m_paddr_i,
  input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0] m_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]             m_prdata_o,
  output logic [NUM_MASTERS-1:0]                m_pready_o,
  output logic [NUM_MASTERS-1:0]                m_pslverr_o,
  output logic                                  psel_o,
  output logic                                  penable_o,
  output logic                                  pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]             paddr_o,
  output logic [APB_DATA_WIDTH-1:0]             pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]             prdata_i,
  input  logic                                  pready_i,
  input  logic                                  pslverr_i
);

  localparam int IW = idx_width(NUM_MASTERS);

  arb_state_t             state;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          ptr_next;
  logic [NUM_MASTERS-1:0] unused_pick_oh;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   timeout_hit;
  logic                   to_flag;
  logic                   unused_penable;

  // Upstream penable only matters for protocol. Arbitration uses psel alone.
  assign unused_penable = ^m_penable_i;

  apb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_picker (
    .req     (m_psel_i),
    .ptr     (rr_ptr),
    .gnt_oh  (unused_pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign ptr_next  = (grant_idx == IW'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
  assign psel_o    = (state != ST_IDLE);
  assign penable_o = (state == ST_ACCESS);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  logic [CW-1:0] to_cnt;

  assign timeout_hit = (state == ST_ACCESS) && !pready_i &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // The watchdog counts ACCESS cycles. The flag reports an abort to the winner during the following IDLE cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      to_flag <= timeout_hit;
      if (state == ST_SETUP) begin
        to_cnt <= '0;
      end else if (state == ST_ACCESS) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign to_flag     = 1'b0;
`endif

  // Transfer FSM. The winner's command is captured at grant, so upstream changes during the transfer do not reach the slave.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_idx <= pick_idx;
            pwrite_o  <= m_pwrite_i[pick_idx];
            paddr_o   <= m_paddr_i[int'(pick_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            pwdata_o  <= m_pwdata_i[int'(pick_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          if (pready_i || timeout_hit) begin
            state  <= ST_IDLE;
            rr_ptr <= ptr_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The completion goes only to the granted master. A watchdog abort is reported as an error completion.
  always_comb begin
    m_pready_o  = '0;
    m_pslverr_o = '0;
    if ((state == ST_ACCESS) && pready_i) begin
      m_pready_o[grant_idx]  = 1'b1;
      m_pslverr_o[grant_idx] = pslverr_i;
    end else if (to_flag) begin
      m_pready_o[grant_idx]  = 1'b1;
      m_pslverr_o[grant_idx] = 1'b1;
    end
  end

  assign m_prdata_o = prdata_i;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with two masters and a hand-driven slave.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: the slave's pready is scripted for each scenario.
module tb_apb_master_arbiter;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 256;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  m_psel_i = '0;
  logic [1:0]  m_penable_i = '0;
  logic [1:0]  m_pwrite_i = '0;
  logic [63:0] m_paddr_i = '0;
  logic [63:0] m_pwdata_i = '0;
  logic [31:0] m_prdata_o;
  logic [1:0]  m_pready_o;
  logic [1:0]  m_pslverr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  int total = 0;
  int bad   = 0;

  apb_master_arbiter #(
    .NUM_MASTERS    (2),
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m_psel_i    (m_psel_i),
    .m_penable_i (m_penable_i),
    .m_pwrite_i  (m_pwrite_i),
    .m_paddr_i   (m_paddr_i),
    .m_pwdata_i  (m_pwdata_i),
    .m_prdata_o  (m_prdata_o),
    .m_pready_o  (m_pready_o),
    .m_pslverr_o (m_pslverr_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni   = 1'b0;
    m_psel_i = 2'b11;
    tick();
    tick();
    total++; if (psel_o !== 1'b0) begin bad++; $display("FAIL rst_psel got %b want 0", psel_o); end
    total++; if (penable_o !== 1'b0) begin bad++; $display("FAIL rst_penable got %b want 0", penable_o); end
    total++; if (m_pready_o !== 2'b00) begin bad++; $display("FAIL rst_pready got %b want 00", m_pready_o); end
    total++; if ({pwrite_o, paddr_o, pwdata_o} !== 65'd0) begin bad++; $display("FAIL rst_cmd got %b/%h/%h want 0", pwrite_o, paddr_o, pwdata_o); end
    m_psel_i = 2'b00;
    rst_ni   = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    m_psel_i          = 2'b01;
    m_pwrite_i        = 2'b01;
    m_paddr_i[31:0]   = 32'h1A10_0004;
    m_pwdata_i[31:0]  = 32'hDEAD_BEEF;
    pready_i          = 1'b1;
    #1;
    total++; if (psel_o !== 1'b0) begin bad++; $display("FAIL sw_idle_psel got %b want 0", psel_o); end
    tick();
    total++; if ({psel_o, penable_o} !== 2'b10) begin bad++; $display("FAIL sw_setup got %b want 10", {psel_o, penable_o}); end
    total++; if (m_pready_o !== 2'b00) begin bad++; $display("FAIL sw_setup_pready got %b want 00", m_pready_o); end
    total++; if (paddr_o !== 32'h1A10_0004 || pwrite_o !== 1'b1) begin bad++; $display("FAIL sw_addr got %h/%b want 1a100004/1", paddr_o, pwrite_o); end
    total++; if (pwdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata got %h want deadbeef", pwdata_o); end
    tick();
    total++; if ({psel_o, penable_o} !== 2'b11) begin bad++; $display("FAIL sw_access got %b want 11", {psel_o, penable_o}); end
    total++; if (m_pready_o !== 2'b01) begin bad++; $display("FAIL sw_pready got %b want 01", m_pready_o); end
    m_psel_i = 2'b00;
    tick();
    total++; if (psel_o !== 1'b0 || m_pready_o !== 2'b00) begin bad++; $display("FAIL sw_back_idle got %b/%b want 0/00", psel_o, m_pready_o); end
  endtask

  task automatic test_alternate();
    logic [31:0] rd;
    rst_ni = 1'b0;
    tick();
    rst_ni            = 1'b1;
    m_pwrite_i        = 2'b00;
    m_paddr_i[31:0]   = 32'h0000_0100;
    m_paddr_i[63:32]  = 32'h0000_0200;
    m_psel_i          = 2'b11;
    pready_i          = 1'b1;
    for (int t = 0; t < 4; t++) begin
      rd       = 32'hC0DE_0000 + 32'(t);
      prdata_i = rd;
      tick();
      total++; if (paddr_o !== ((t % 2 == 0) ? 32'h100 : 32'h200)) begin bad++; $display("FAIL alt_addr%0d got %h want %h", t, paddr_o, (t % 2 == 0) ? 32'h100 : 32'h200); end
      tick();
      total++; if (m_pready_o !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL alt_pready%0d got %b want %b", t, m_pready_o, (t % 2 == 0) ? 2'b01 : 2'b10); end
      total++; if (m_prdata_o !== rd) begin bad++; $display("FAIL alt_rdata%0d got %h want %h", t, m_prdata_o, rd); end
      tick();
      total++; if (psel_o !== 1'b0) begin bad++; $display("FAIL alt_gap%0d got %b want 0", t, psel_o); end
    end
    m_psel_i = 2'b00;
    tick();
  endtask

  task automatic test_wait_state_and_slverr();
    m_pwrite_i        = 2'b01;
    m_paddr_i[31:0]   = 32'h0000_0300;
    m_paddr_i[63:32]  = 32'h0000_0400;
    m_pwdata_i[31:0]  = 32'h1234_5678;
    pready_i          = 1'b0;
    m_psel_i          = 2'b01;
    tick();
    m_psel_i = 2'b11;
    total++; if (paddr_o !== 32'h300) begin bad++; $display("FAIL ws_addr got %h want 300", paddr_o); end
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        m_paddr_i[31:0]  = 32'h0000_FFFF;
        m_pwdata_i[31:0] = 32'h0;
        #1;
      end
      total++; if (penable_o !== 1'b1 || m_pready_o !== 2'b00) begin bad++; $display("FAIL ws_hold%0d got %b/%b want 1/00", i, penable_o, m_pready_o); end
      total++; if (paddr_o !== 32'h300 || pwdata_o !== 32'h1234_5678) begin bad++; $display("FAIL ws_stable%0d got %h/%h want 300/12345678", i, paddr_o, pwdata_o); end
      tick();
    end
    pready_i = 1'b1;
    #1;
    total++; if (m_pready_o !== 2'b01) begin bad++; $display("FAIL ws_done got %b want 01", m_pready_o); end
    m_psel_i = 2'b10;
    tick();
    total++; if (psel_o !== 1'b0) begin bad++; $display("FAIL ws_gap got %b want 0", psel_o); end
    pslverr_i = 1'b1;
    tick();
    total++; if (paddr_o !== 32'h400 || pwrite_o !== 1'b0) begin bad++; $display("FAIL se_addr got %h/%b want 400/0", paddr_o, pwrite_o); end
    total++; if (m_pready_o !== 2'b00 || m_pslverr_o !== 2'b00) begin bad++; $display("FAIL se_setup got %b/%b want 00/00", m_pready_o, m_pslverr_o); end
    tick();
    total++; if (m_pready_o !== 2'b10) begin bad++; $display("FAIL se_pready got %b want 10", m_pready_o); end
    total++; if (m_pslverr_o !== 2'b10) begin bad++; $display("FAIL se_pslverr got %b want 10", m_pslverr_o); end
    m_psel_i  = 2'b00;
    pslverr_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    pready_i = 1'b1;
    m_psel_i = 2'b01;
    tick();
    tick();
    m_psel_i = 2'b00;
    tick();
    m_paddr_i[31:0]  = 32'h0000_0500;
    m_paddr_i[63:32] = 32'h0000_0600;
    pready_i         = 1'b0;
    m_psel_i         = 2'b11;
    tick();
    total++; if (paddr_o !== 32'h600) begin bad++; $display("FAIL rm_pre_addr got %h want 600", paddr_o); end
    tick();
    total++; if (penable_o !== 1'b1) begin bad++; $display("FAIL rm_access got %b want 1", penable_o); end
    rst_ni = 1'b0;
    tick();
    total++; if ({psel_o, penable_o} !== 2'b00) begin bad++; $display("FAIL rm_abort got %b want 00", {psel_o, penable_o}); end
    total++; if (m_pready_o !== 2'b00 || paddr_o !== 32'h0) begin bad++; $display("FAIL rm_state got %b/%h want 00/0", m_pready_o, paddr_o); end
    rst_ni = 1'b1;
    tick();
    total++; if (paddr_o !== 32'h500 || psel_o !== 1'b1) begin bad++; $display("FAIL rm_post_win got %h/%b want 500/1", paddr_o, psel_o); end
    pready_i = 1'b1;
    tick();
    total++; if (m_pready_o !== 2'b01) begin bad++; $display("FAIL rm_post_done got %b want 01", m_pready_o); end
    m_psel_i = 2'b00;
    tick();
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    m_paddr_i[31:0]  = 32'h0000_0700;
    m_paddr_i[63:32] = 32'h0000_0800;
    pready_i         = 1'b0;
    m_psel_i         = 2'b11;
    tick();
    total++; if (paddr_o !== 32'h800) begin bad++; $display("FAIL to_addr got %h want 800", paddr_o); end
    for (int i = 0; i < 16; i++) begin
      tick();
      total++; if (penable_o !== 1'b1 || m_pready_o !== 2'b00) begin bad++; $display("FAIL to_wait%0d got %b/%b want 1/00", i, penable_o, m_pready_o); end
    end
    tick();
    total++; if (psel_o !== 1'b0) begin bad++; $display("FAIL to_psel got %b want 0", psel_o); end
    total++; if (m_pready_o !== 2'b10 || m_pslverr_o !== 2'b10) begin bad++; $display("FAIL to_err got %b/%b want 10/10", m_pready_o, m_pslverr_o); end
    m_psel_i = 2'b01;
    tick();
    total++; if (paddr_o !== 32'h700 || psel_o !== 1'b1) begin bad++; $display("FAIL to_next got %h/%b want 700/1", paddr_o, psel_o); end
    pready_i = 1'b1;
    tick();
    m_psel_i = 2'b00;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_wait_state_and_slverr();
    test_reset_mid_transfer();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
